// File: rtl/antitheft_timer.sv
// Delay store and seconds countdown for the anti-theft controller; pulses expired when the selected delay elapses.
// Optional build macro TIMER_MONITOR_EN adds the seconds_left output.
module antitheft_timer #(
  parameter int CLK_FREQ     = 50000000,
  parameter int T_ARM_DEF    = 6,
  parameter int T_DRIVER_DEF = 8,
  parameter int T_PASS_DEF   = 15,
  parameter int T_ALARM_DEF  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
`ifdef TIMER_MONITOR_EN
  output logic [3:0] seconds_left,
`endif
  output logic       expired,
  output logic       one_hz_enable
);

  localparam int PS_W = $clog2(CLK_FREQ);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_FREQ - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state, state_next;
  logic [3:0]      param [4];
  logic [PS_W-1:0] prescaler, prescaler_next;
  logic [3:0]      counter, counter_next;
  logic [1:0]      interval_q;
  logic            start_d;
  logic            expired_next, one_hz_next;
  logic            tick, load;

  function automatic logic [3:0] dec_sat(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  assign tick = (prescaler == PS_MAX);
  // From IDLE only a fresh rising edge starts a countdown; a reprogram on the same edge suppresses the load.
  assign load = start_timer && !reprogram &&
                (!start_d || (state != IDLE && interval != interval_q));

  always_comb begin
    state_next     = state;
    counter_next   = counter;
    expired_next   = 1'b0;
    prescaler_next = tick ? '0 : prescaler + PS_W'(1);
    one_hz_next    = tick;
    if (reprogram || !start_timer) begin
      state_next   = IDLE;
      counter_next = 4'd0;
    end else if (load) begin
      prescaler_next = '0;
      one_hz_next    = 1'b0;
      counter_next   = param[interval];
      if (param[interval] == 4'd0) begin
        state_next   = DONE;
        expired_next = 1'b1;
      end else begin
        state_next = COUNT;
      end
    end else if (state == COUNT && tick) begin
      counter_next = dec_sat(counter);
      if (counter == 4'd1) begin
        state_next   = DONE;
        expired_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      prescaler     <= '0;
      counter       <= 4'd0;
      start_d       <= 1'b0;
      interval_q    <= 2'd0;
      expired       <= 1'b0;
      one_hz_enable <= 1'b0;
      param[0]      <= 4'(T_ARM_DEF);
      param[1]      <= 4'(T_DRIVER_DEF);
      param[2]      <= 4'(T_PASS_DEF);
      param[3]      <= 4'(T_ALARM_DEF);
    end else begin
      state         <= state_next;
      prescaler     <= prescaler_next;
      counter       <= counter_next;
      start_d       <= start_timer;
      expired       <= expired_next;
      one_hz_enable <= one_hz_next;
      if (load) interval_q <= interval;
      if (reprogram) param[time_param_sel] <= time_value;
    end
  end

`ifdef TIMER_MONITOR_EN
  assign seconds_left = counter;
`endif

endmodule

// File: tb/tb_antitheft_timer.sv
// Bench for antitheft_timer: deadline-based reference model checked every cycle, plus directed latency checks.
module tb_antitheft_timer;
  localparam int CF = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_timer = 1'b0;
  logic [1:0] interval = 2'd0;
  logic       reprogram = 1'b0;
  logic [1:0] time_param_sel = 2'd0;
  logic [3:0] time_value = 4'd0;
  logic       expired, one_hz_enable;
`ifdef TIMER_MONITOR_EN
  logic [3:0] seconds_left;
`endif

  always #5 clock = ~clock;

  antitheft_timer #(.CLK_FREQ(CF)) dut (
    .clock(clock), .reset(reset), .start_timer(start_timer), .interval(interval),
    .reprogram(reprogram), .time_param_sel(time_param_sel), .time_value(time_value),
`ifdef TIMER_MONITOR_EN
    .seconds_left(seconds_left),
`endif
    .expired(expired), .one_hz_enable(one_hz_enable)
  );

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: a load fixes an absolute expiry edge; seconds tick every CF edges after the last prescaler restart.
  int cyc, ref_cyc, deadline, last_iv, e_left;
  int m_param [4];
  bit active, start_prev, loaded, e_exp, e_hz;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc = 0; ref_cyc = 0; deadline = -1; last_iv = 0;
      active = 0; start_prev = 0; e_exp = 0; e_hz = 0; e_left = 0;
      m_param[0] = 6; m_param[1] = 8; m_param[2] = 15; m_param[3] = 10;
    end else begin
      cyc++;
      loaded = 0;
      e_exp = 0;
      if (reprogram) begin
        m_param[time_param_sel] = time_value;
        active = 0; deadline = -1;
      end else if (start_timer && (!start_prev || (active && int'(interval) != last_iv))) begin
        loaded = 1; last_iv = int'(interval); ref_cyc = cyc; active = 1;
        if (m_param[interval] == 0) begin
          e_exp = 1; deadline = -1;
        end else begin
          deadline = cyc + m_param[interval] * CF;
        end
      end else if (!start_timer) begin
        active = 0; deadline = -1;
      end else if (deadline == cyc) begin
        e_exp = 1; deadline = -1;
      end
      e_hz = !loaded && (cyc > ref_cyc) && ((cyc - ref_cyc) % CF == 0);
      e_left = (deadline >= 0) ? (deadline - cyc + CF - 1) / CF : 0;
      start_prev = start_timer;
    end
  end

  int exp_cnt = 0, hz_cnt = 0, exp_edge = -1;

  always @(negedge clock) begin
    check("expired", int'(expired), int'(e_exp));
    check("one_hz_enable", int'(one_hz_enable), int'(e_hz));
`ifdef TIMER_MONITOR_EN
    check("seconds_left", int'(seconds_left), e_left);
`endif
    if (expired === 1'b1) begin
      exp_cnt++;
      exp_edge = cyc;
    end
    if (one_hz_enable === 1'b1) hz_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  int load_edge;

  initial begin
    step(3);
    check("reset_expired", int'(expired), 0);
    check("reset_one_hz", int'(one_hz_enable), 0);
    reset = 1'b0;
    hz_cnt = 0; exp_cnt = 0;
    step(13);
    check("idle_hz_pulses", hz_cnt, 3);
    check("idle_no_expired", exp_cnt, 0);

    // driver delay 8 s -> 32 edges
    interval = 2'd1; start_timer = 1'b1; load_edge = cyc + 1; exp_cnt = 0;
    step(45);
    check("driver_pulse_count", exp_cnt, 1);
    check("driver_latency", exp_edge - load_edge, 32);
    step(10);
    check("driver_no_repeat", exp_cnt, 1);

    // interval switch to alarm (10 s) ten edges into the countdown
    start_timer = 1'b0; step(1);
    start_timer = 1'b1; load_edge = cyc + 1; exp_cnt = 0;
    step(10);
    interval = 2'd3; load_edge = cyc + 1;
    step(50);
    check("switch_pulse_count", exp_cnt, 1);
    check("switch_latency", exp_edge - load_edge, 40);

    // arm delay reprogrammed to 3 then 0
    start_timer = 1'b0; reprogram = 1'b1; time_param_sel = 2'd0; time_value = 4'd3;
    step(1);
    reprogram = 1'b0; interval = 2'd0; start_timer = 1'b1; load_edge = cyc + 1; exp_cnt = 0;
    step(20);
    check("arm3_pulse_count", exp_cnt, 1);
    check("arm3_latency", exp_edge - load_edge, 12);
    start_timer = 1'b0; reprogram = 1'b1; time_value = 4'd0;
    step(1);
    reprogram = 1'b0; start_timer = 1'b1; load_edge = cyc + 1; exp_cnt = 0;
    step(5);
    check("arm0_pulse_count", exp_cnt, 1);
    check("arm0_latency", exp_edge - load_edge, 0);

    // passenger delay aborted after 20 edges, then a full reload
    start_timer = 1'b0; interval = 2'd2; step(1);
    start_timer = 1'b1; exp_cnt = 0;
    step(20);
    start_timer = 1'b0;
    step(70);
    check("abort_no_expired", exp_cnt, 0);
    start_timer = 1'b1; load_edge = cyc + 1;
    step(70);
    check("pass_pulse_count", exp_cnt, 1);
    check("pass_latency", exp_edge - load_edge, 60);

    // reset mid-countdown restores the 6 s arm delay
    start_timer = 1'b0; step(1);
    interval = 2'd1; start_timer = 1'b1; exp_cnt = 0;
    step(10);
    reset = 1'b1; start_timer = 1'b0;
    #1;
    check("async_reset_expired", int'(expired), 0);
    check("async_reset_one_hz", int'(one_hz_enable), 0);
    step(2);
    reset = 1'b0;
    step(1);
    check("reset_no_expired", exp_cnt, 0);
    interval = 2'd0; start_timer = 1'b1; load_edge = cyc + 1;
    step(30);
    check("default_arm_pulse_count", exp_cnt, 1);
    check("default_arm_latency", exp_edge - load_edge, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/antitheft_timer.md
Name: antitheft_timer

Overview:
Time-parameter store and countdown timer for the automotive anti-theft controller. It serves as the counterpart of the controller's start_timer/interval request interface, and it returns the expired and one_hz_enable signals the controller consumes. It holds four programmable delays, counts the selected delay in seconds, and pulses expired when the delay elapses.

Parameters:
CLK_FREQ, 50000000, clock cycles per second (prescaler divisor, >= 2)
T_ARM_DEF, 6, reset value of arming delay (s)
T_DRIVER_DEF, 8, reset value of driver-door delay (s)
T_PASS_DEF, 15, reset value of passenger-door delay (s)
T_ALARM_DEF, 10, reset value of siren-on time (s)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
start_timer  in  1  level request from controller; high while a timed state is active
interval  in  2  delay select: 00 arm, 01 driver, 10 passenger, 11 alarm
reprogram  in  1  write strobe for parameter store
time_param_sel  in  2  parameter to write (same encoding as interval)
time_value  in  4  new delay in seconds, 0..15
expired  out  1  one-cycle pulse when selected delay has elapsed
one_hz_enable  out  1  one-cycle pulse once per second

Behaviour:
- Reset (async, clock is clock, reset is reset, active-high): parameter regs <= *_DEF values; prescaler <= 0; counter <= 0; state IDLE; start_d <= 0; expired = 0; one_hz_enable = 0.
- Prescaler: counts 0..CLK_FREQ-1 and wraps. one_hz_enable is registered and high for the single cycle after prescaler == CLK_FREQ-1. It free-runs in all states because the controller uses it for status blinking. It is cleared to 0 on every load event.
- Load event: occurs at a clock edge where start_timer=1 and either start_d=0 (rising edge) or interval differs from the interval latched at the last load. Effects: counter <= param[interval]; prescaler <= 0; interval latched.
- States:
  - IDLE: on load event -> COUNT, or -> DONE with expired pulse if the loaded value is 0.
  - COUNT: on one_hz_enable decrement counter. When decrementing from 1, counter -> 0, expired <= 1 for one cycle, -> DONE. A load event here restarts the countdown with the new value.
  - DONE: expired stays 0, with no repeat pulses. A load event -> COUNT (reload). start_timer=0 -> IDLE.
- Latency: expired rises N*CLK_FREQ clock edges after the load edge, N = loaded value. For N=0, expired rises at the load edge itself.
- start_timer falling in COUNT: abort -> IDLE, counter <= 0, no expired pulse.
- Reprogram: when reprogram=1 at an edge, param[time_param_sel] <= time_value. Any active countdown is aborted -> IDLE with no expired pulse. A new rising edge of start_timer is required to restart.
- Priority when reprogram and a load event occur on the same edge: the reprogram write and abort win; the load is ignored.
- Widths: counter is 4 bits and never underflows. The prescaler is wide enough for CLK_FREQ-1.

Optional Feature:
TIMER_MONITOR_EN. When defined, an extra output port seconds_left [3:0] equals the current counter value: 0 in IDLE and DONE, otherwise the remaining seconds. When undefined, the port is absent and behaviour is otherwise identical.

Test Plan:
- CLK_FREQ=4, reset released, start_timer=0 -> expired stays 0; one_hz_enable pulses at cycles 4, 8, 12 after release, each 1 cycle wide.
- start_timer 0->1 with interval=01 (default 8), held high -> single expired pulse exactly 32 edges after the load edge; no further pulse while start_timer stays 1.
- In COUNT with interval=01, switch interval to 11 at 10 edges after load -> countdown restarts; expired arrives 40 edges after the switch edge.
- reprogram=1, time_param_sel=00, time_value=3, then start_timer rise with interval=00 -> expired 12 edges after load. Repeat with time_value=0 -> expired at the load edge.
- Start interval=10 (15 s), drop start_timer after 20 edges -> no expired pulse; the next start rise reloads the full 15 s (60 edges).
- Assert reset for 1 cycle mid-countdown -> outputs 0 immediately, parameters return to defaults (arm delay back to 6), no expired pulse.
